hdmi_packet_scheduler: RTL and testbench

Per-slot scheduler for the HDMI data-island packet datapath. At each packet slot it chooses which packet is transmitted: audio sample, audio clock regeneration (ACR), one of the InfoFrames (AVI, Audio, optionally SPD), or a null packet. It runs in the pixel clock domain, between the audio, ACR and InfoFrame packet generators and the header/subpacket mux feeding the TMDS data-island encoder. It tracks per-period InfoFrame obligations and bounds ACR starvation under heavy audio traffic.

---
 rtl/hdmi_packet_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_hdmi_packet_scheduler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_packet_scheduler.sv
// HDMI data-island packet scheduler: picks audio, ACR, InfoFrame or null per 32-cycle slot.
// Define HDMI_SPD_EN to add the SPD InfoFrame (0x83) to the per-period InfoFrame set.
module hdmi_packet_scheduler #(
  parameter int unsigned INFOFRAME_PERIOD = 1,
  parameter int unsigned ACR_MAX_DEFER    = 2
) (
  input  logic       clk_pixel,
  input  logic       reset_n,
  input  logic       frame_start,
  input  logic       packet_enable,
  input  logic       audio_req,
  input  logic       acr_req,
  output logic [7:0] packet_type,
  output logic       packet_busy,
  output logic       audio_ack,
  output logic       acr_ack,
  output logic       infoframe_missed
);

  localparam int unsigned TYPE_W   = 8;
  localparam int unsigned SLOT_W   = 5;
  localparam int unsigned FRAME_W  = 4;
  localparam int unsigned DEFER_W  = 3;
  localparam int unsigned SLOT_LEN = 32;

  localparam logic [TYPE_W-1:0] PT_NULL  = 8'h00;
  localparam logic [TYPE_W-1:0] PT_ACR   = 8'h01;
  localparam logic [TYPE_W-1:0] PT_AUDIO = 8'h02;
  localparam logic [TYPE_W-1:0] PT_AVI   = 8'h82;
  localparam logic [TYPE_W-1:0] PT_SPD   = 8'h83;
  localparam logic [TYPE_W-1:0] PT_AIF   = 8'h84;

  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SLOT_LEN - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(INFOFRAME_PERIOD - 1);
  localparam logic [DEFER_W-1:0] DEFER_MAX  = DEFER_W'(ACR_MAX_DEFER);

`ifdef HDMI_SPD_EN
  localparam logic SPD_EN = 1'b1;
`else
  localparam logic SPD_EN = 1'b0;
`endif

  typedef enum logic {S_IDLE, S_SLOT} state_e;

  state_e              state_q, state_d;
  logic [SLOT_W-1:0]   slot_cnt_q, slot_cnt_d;
  logic [FRAME_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [DEFER_W-1:0]  defer_q, defer_d;
  logic                acr_pending_q, acr_pending_d;
  logic                pend_avi_q, pend_avi_d;
  logic                pend_aif_q, pend_aif_d;
  logic                pend_spd_q, pend_spd_d;
  logic [TYPE_W-1:0]   packet_type_q, packet_type_d;
  logic                packet_busy_q, packet_busy_d;
  logic                audio_ack_q, audio_ack_d;
  logic                acr_ack_q, acr_ack_d;
  logic                missed_q, missed_d;

  logic accept_c;
  logic wrap_c;
  logic clr_acr, clr_avi, clr_aif, clr_spd;

  // A new slot may start in IDLE or on the last cycle of the running slot.
  assign accept_c = packet_enable && ((state_q == S_IDLE) || (slot_cnt_q == SLOT_LAST));
  assign wrap_c   = frame_start && (frame_cnt_q == FRAME_LAST);

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      slot_cnt_q    <= '0;
      frame_cnt_q   <= '0;
      defer_q       <= '0;
      acr_pending_q <= 1'b0;
      pend_avi_q    <= 1'b0;
      pend_aif_q    <= 1'b0;
      pend_spd_q    <= 1'b0;
      packet_type_q <= PT_NULL;
      packet_busy_q <= 1'b0;
      audio_ack_q   <= 1'b0;
      acr_ack_q     <= 1'b0;
      missed_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_cnt_q    <= slot_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      defer_q       <= defer_d;
      acr_pending_q <= acr_pending_d;
      pend_avi_q    <= pend_avi_d;
      pend_aif_q    <= pend_aif_d;
      pend_spd_q    <= pend_spd_d;
      packet_type_q <= packet_type_d;
      packet_busy_q <= packet_busy_d;
      audio_ack_q   <= audio_ack_d;
      acr_ack_q     <= acr_ack_d;
      missed_q      <= missed_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    slot_cnt_d    = slot_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    defer_d       = defer_q;
    packet_type_d = packet_type_q;
    audio_ack_d   = 1'b0;
    acr_ack_d     = 1'b0;
    missed_d      = 1'b0;
    clr_acr       = 1'b0;
    clr_avi       = 1'b0;
    clr_aif       = 1'b0;
    clr_spd       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (packet_enable) begin
          state_d    = S_SLOT;
          slot_cnt_d = '0;
        end
      end
      S_SLOT: begin
        slot_cnt_d = slot_cnt_q + SLOT_W'(1);
        if ((slot_cnt_q == SLOT_LAST) && !packet_enable) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Source selection; ACR pre-empts audio once it has been deferred ACR_MAX_DEFER times.
    if (accept_c) begin
      if (acr_pending_q && (defer_q == DEFER_MAX)) begin
        packet_type_d = PT_ACR;
        clr_acr       = 1'b1;
        acr_ack_d     = 1'b1;
      end else if (audio_req) begin
        packet_type_d = PT_AUDIO;
        audio_ack_d   = 1'b1;
        if (acr_pending_q && (defer_q != '1)) begin
          defer_d = defer_q + DEFER_W'(1);
        end
      end else if (acr_pending_q) begin
        packet_type_d = PT_ACR;
        clr_acr       = 1'b1;
        acr_ack_d     = 1'b1;
      end else if (pend_avi_q) begin
        packet_type_d = PT_AVI;
        clr_avi       = 1'b1;
      end else if (pend_aif_q) begin
        packet_type_d = PT_AIF;
        clr_aif       = 1'b1;
      end else if (pend_spd_q) begin
        packet_type_d = PT_SPD;
        clr_spd       = 1'b1;
      end else begin
        packet_type_d = PT_NULL;
      end
    end

    if (!acr_pending_q || clr_acr) begin
      defer_d = '0;
    end

    if (frame_start) begin
      frame_cnt_d = wrap_c ? '0 : frame_cnt_q + FRAME_W'(1);
    end

    // Clears apply first so a coincident request or period wrap re-arms the flag.
    acr_pending_d = (acr_pending_q & ~clr_acr) | acr_req;
    pend_avi_d    = (pend_avi_q & ~clr_avi) | wrap_c;
    pend_aif_d    = (pend_aif_q & ~clr_aif) | wrap_c;
    pend_spd_d    = ((pend_spd_q & ~clr_spd) | wrap_c) & SPD_EN;

    missed_d = wrap_c & ((pend_avi_q & ~clr_avi) | (pend_aif_q & ~clr_aif) |
                         (pend_spd_q & ~clr_spd));

    packet_busy_d = (state_d == S_SLOT);
  end

  assign packet_type      = packet_type_q;
  assign packet_busy      = packet_busy_q;
  assign audio_ack        = audio_ack_q;
  assign acr_ack          = acr_ack_q;
  assign infoframe_missed = missed_q;

endmodule

// File: tb/tb_hdmi_packet_scheduler.sv
// Bench for hdmi_packet_scheduler: directed scenarios plus randomized traffic against a slot-level model.
module tb_hdmi_packet_scheduler;

  localparam int unsigned PERIOD0 = 1;
  localparam int unsigned DEFER0  = 2;
  localparam int unsigned PERIOD1 = 3;
  localparam int unsigned DEFER1  = 0;

`ifdef HDMI_SPD_EN
  localparam bit SPD = 1'b1;
`else
  localparam bit SPD = 1'b0;
`endif

  logic clk_pixel     = 1'b0;
  logic reset_n       = 1'b1;
  logic frame_start   = 1'b0;
  logic packet_enable = 1'b0;
  logic audio_req     = 1'b0;
  logic acr_req       = 1'b0;

  logic [7:0] pt0, pt1;
  logic       busy0, busy1, aack0, aack1, cack0, cack1, miss0, miss1;

  int n_checks = 0;
  int n_errors = 0;

  hdmi_packet_scheduler #(.INFOFRAME_PERIOD(PERIOD0), .ACR_MAX_DEFER(DEFER0)) u_dut0 (
    .clk_pixel(clk_pixel), .reset_n(reset_n), .frame_start(frame_start),
    .packet_enable(packet_enable), .audio_req(audio_req), .acr_req(acr_req),
    .packet_type(pt0), .packet_busy(busy0), .audio_ack(aack0), .acr_ack(cack0),
    .infoframe_missed(miss0));

  hdmi_packet_scheduler #(.INFOFRAME_PERIOD(PERIOD1), .ACR_MAX_DEFER(DEFER1)) u_dut1 (
    .clk_pixel(clk_pixel), .reset_n(reset_n), .frame_start(frame_start),
    .packet_enable(packet_enable), .audio_req(audio_req), .acr_req(acr_req),
    .packet_type(pt1), .packet_busy(busy1), .audio_ack(aack1), .acr_ack(cack1),
    .infoframe_missed(miss1));

  always #5 clk_pixel = ~clk_pixel;

  // Reference model: one entry per DUT; InfoFrame index 0=AVI, 1=AIF, 2=SPD.
  int         m_per[2];
  int         m_mxd[2];
  bit         m_acr[2];
  int         m_def[2];
  bit         m_pend[2][3];
  int         m_frm[2];
  int         m_last[2];
  int         cyc = 0;
  logic [7:0] e_type[2];
  bit         e_busy[2], e_aack[2], e_cack[2], e_miss[2];
  logic [7:0] if_code[3] = '{8'h82, 8'h84, 8'h83};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t got=0x%0h exp=0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_acr[k]  = 1'b0;
      m_def[k]  = 0;
      m_frm[k]  = 0;
      m_last[k] = -1000;
      for (int i = 0; i < 3; i++) m_pend[k][i] = 1'b0;
      e_type[k] = 8'h00;
      e_busy[k] = 1'b0; e_aack[k] = 1'b0; e_cack[k] = 1'b0; e_miss[k] = 1'b0;
    end
  endtask

  // Advance model k across one clock edge using the inputs present at that edge.
  task automatic model_step(input int k);
    bit accept, wrap, old_acr, sent_acr;
    int sent_if;
    accept   = packet_enable && ((cyc - m_last[k]) >= 32);
    wrap     = frame_start && (m_frm[k] == m_per[k] - 1);
    old_acr  = m_acr[k];
    sent_acr = 1'b0;
    sent_if  = -1;
    e_aack[k] = 1'b0; e_cack[k] = 1'b0; e_miss[k] = 1'b0;
    if (accept) begin
      m_last[k] = cyc;
      if (m_acr[k] && m_def[k] == m_mxd[k]) begin
        e_type[k] = 8'h01; sent_acr = 1'b1;
      end else if (audio_req) begin
        e_type[k] = 8'h02; e_aack[k] = 1'b1;
        if (m_acr[k] && m_def[k] < 7) m_def[k]++;
      end else if (m_acr[k]) begin
        e_type[k] = 8'h01; sent_acr = 1'b1;
      end else begin
        e_type[k] = 8'h00;
        for (int i = 0; i < 3; i++)
          if (sent_if < 0 && m_pend[k][i]) sent_if = i;
        if (sent_if >= 0) e_type[k] = if_code[sent_if];
      end
    end
    if (wrap)
      for (int i = 0; i < 3; i++)
        if (m_pend[k][i] && i != sent_if) e_miss[k] = 1'b1;
    if (sent_acr) begin
      e_cack[k] = 1'b1; m_acr[k] = 1'b0;
    end
    if (sent_if >= 0) m_pend[k][sent_if] = 1'b0;
    if (sent_acr || !old_acr) m_def[k] = 0;
    if (acr_req) m_acr[k] = 1'b1;
    if (wrap) begin
      m_pend[k][0] = 1'b1; m_pend[k][1] = 1'b1; m_pend[k][2] = SPD;
    end
    if (frame_start) m_frm[k] = wrap ? 0 : m_frm[k] + 1;
    e_busy[k] = (cyc - m_last[k]) < 32;
  endtask

  task automatic compare_all();
    check("type0", 32'(pt0), 32'(e_type[0]));
    check("busy0", 32'(busy0), 32'(e_busy[0]));
    check("aack0", 32'(aack0), 32'(e_aack[0]));
    check("cack0", 32'(cack0), 32'(e_cack[0]));
    check("miss0", 32'(miss0), 32'(e_miss[0]));
    check("type1", 32'(pt1), 32'(e_type[1]));
    check("busy1", 32'(busy1), 32'(e_busy[1]));
    check("aack1", 32'(aack1), 32'(e_aack[1]));
    check("cack1", 32'(cack1), 32'(e_cack[1]));
    check("miss1", 32'(miss1), 32'(e_miss[1]));
  endtask

  task automatic step(input bit fs, input bit pe, input bit ar, input bit cr);
    frame_start = fs; packet_enable = pe; audio_req = ar; acr_req = cr;
    @(posedge clk_pixel);
    model_step(0);
    model_step(1);
    cyc++;
    #1;
    compare_all();
  endtask

  task automatic idle(input int n, input bit ar);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, ar, 1'b0);
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    frame_start = 1'b0; packet_enable = 1'b0; audio_req = 1'b0; acr_req = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("rst_type", 32'(pt0), 32'h00);
    check("rst_busy", 32'(busy0), 32'h0);
    repeat (2) begin
      @(posedge clk_pixel);
      cyc++;
    end
    #1;
    compare_all();
    reset_n = 1'b1;
  endtask

  initial begin
    logic [7:0] exp_if[4];
    logic [7:0] exp_ac[4];
    bit audio_lvl;
    m_per[0] = PERIOD0; m_mxd[0] = DEFER0;
    m_per[1] = PERIOD1; m_mxd[1] = DEFER1;
    model_reset();
    do_reset();

    // Reset mid-slot with ACR pending, then a request-free slot must be null.
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    idle(5, 1'b1);
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("d1_first_type", 32'(pt0), 32'h00);
    check("d1_first_cack", 32'(cack0), 32'h0);
    idle(31, 1'b0);

    // InfoFrame drain after one period wrap.
    exp_if[0] = 8'h82; exp_if[1] = 8'h84; exp_if[2] = SPD ? 8'h83 : 8'h00; exp_if[3] = 8'h00;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int s = 0; s < 4; s++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      check($sformatf("d2_type%0d", s), 32'(pt0), 32'(exp_if[s]));
      idle(31, 1'b0);
    end

    // ACR bounded deferral under continuous audio.
    exp_ac[0] = 8'h02; exp_ac[1] = 8'h02; exp_ac[2] = 8'h01; exp_ac[3] = 8'h02;
    step(1'b0, 1'b0, 1'b1, 1'b1);
    for (int s = 0; s < 4; s++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0);
      check($sformatf("d3_type%0d", s), 32'(pt0), 32'(exp_ac[s]));
      check($sformatf("d3_cack%0d", s), 32'(cack0), 32'(s == 2));
      idle(31, 1'b1);
    end
    idle(2, 1'b0);

    // packet_enable inside a busy slot is ignored.
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("d4_aack_first", 32'(aack0), 32'h1);
    for (int j = 0; j < 31; j++) begin
      step(1'b0, j == 9, 1'b1, 1'b0);
      check("d4_aack_none", 32'(aack0), 32'h0);
      check("d4_busy", 32'(busy0), 32'h1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("d4_busy_end", 32'(busy0), 32'h0);
    idle(3, 1'b0);

    // ACR request coincident with ACR decision re-arms the flag.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("d6_type_a", 32'(pt0), 32'h01);
    check("d6_cack_a", 32'(cack0), 32'h1);
    idle(31, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("d6_type_b", 32'(pt0), 32'h01);
    check("d6_cack_b", 32'(cack0), 32'h1);
    idle(31, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("d6_type_c", 32'(pt0), 32'h00);
    idle(31, 1'b0);

    // Two period wraps with no slot in between: one missed pulse, flags stay armed.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("d5_miss_first", 32'(miss0), 32'h0);
    idle(3, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("d5_miss_second", 32'(miss0), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("d5_miss_clear", 32'(miss0), 32'h0);
    for (int s = 0; s < 3; s++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      check($sformatf("d5_type%0d", s), 32'(pt0), 32'(exp_if[s]));
      idle(31, 1'b0);
    end

    // Randomized traffic, including occasional asynchronous resets.
    audio_lvl = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) audio_lvl = ~audio_lvl;
      if ($urandom_range(0, 1499) == 0) do_reset();
      step($urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0, audio_lvl,
           $urandom_range(0, 39) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
